// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   UART receiver with an input synchroniser and 3-sample majority voting.
//   A glitch on the start bit is rejected. Each received word carries a
//   parity-error flag and a framing-error flag. Words are buffered in a
//   small show-ahead FIFO, which the host drains with a valid/ack handshake.
//
// Ports
//   clk           system clock
//   rst           asynchronous, active-high reset
//   rx_i          serial input, asynchronous to clk, idle high
//   data_o        data word at the FIFO head
//   parity_err_o  head word had a parity mismatch
//   frame_err_o   head word had a stop bit sampled low
//   data_valid_o  FIFO holds at least one word
//   read_ack_i    pops the head word while data_valid_o is high
//   overrun_o     sticky: a completed frame was dropped on a full FIFO
//   clr_overrun_i clears overrun_o
//   fifo_count_o  number of stored words
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 234,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_i,
    output logic [DATA_BITS-1:0]          data_o,
    output logic                          parity_err_o,
    output logic                          frame_err_o,
    output logic                          data_valid_o,
    input  logic                          read_ack_i,
    output logic                          overrun_o,
    input  logic                          clr_overrun_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int CNTW = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int BIW  = $clog2(DATA_BITS);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int EW   = DATA_BITS + 2;

    localparam logic [CNTW-1:0] SAMP_A   = CNTW'(HALF - 1);
    localparam logic [CNTW-1:0] SAMP_B   = CNTW'(HALF);
    localparam logic [CNTW-1:0] SAMP_C   = CNTW'(HALF + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(CLKS_PER_BIT - 1);
    localparam logic [BIW-1:0]  BIT_LAST = BIW'(DATA_BITS - 1);
    localparam logic            STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic            PAR_ODD  = (PARITY == 1);
    localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync2_q;
    logic                   rx_s;
    logic [CNTW-1:0]        cnt_q, cnt_d;
    logic [1:0]             samp_q, samp_d;
    logic [BIW-1:0]         bit_q, bit_d;
    logic                   stop_q, stop_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_bad_q, par_bad_d;
    logic                   frame_bad_q, frame_bad_d;
    logic                   armed_q, armed_d;
    logic                   maj, decide, bit_end, frame_bad_now;
    logic                   push;
    logic [EW-1:0]          push_entry;

    logic [EW-1:0]          mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_q, rd_q, head_idx;
    logic [CW-1:0]          count_q, count_d;
    logic                   overrun_q, overrun_d;
    logic                   full, empty, pop, wr_en, drop;

    // Two-flop synchroniser; flops reset to the idle level so a reset
    // never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    // Majority of the samples at H-1 and H plus the live sample at H+1.
    assign maj           = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    assign decide        = (cnt_q == SAMP_C);
    assign bit_end       = (cnt_q == CNT_LAST);
    assign frame_bad_now = frame_bad_q | ~maj;
    assign push_entry    = {shift_q, par_bad_q, frame_bad_now};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            samp_q      <= 2'b11;
            bit_q       <= '0;
            stop_q      <= 1'b0;
            shift_q     <= '0;
            par_bad_q   <= 1'b0;
            frame_bad_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            samp_q      <= samp_d;
            bit_q       <= bit_d;
            stop_q      <= stop_d;
            shift_q     <= shift_d;
            par_bad_q   <= par_bad_d;
            frame_bad_q <= frame_bad_d;
            armed_q     <= armed_d;
        end
    end

    // Receiver FSM. The frame completes at the mid-point decision of the
    // final stop bit, so the next start edge can be caught even if the
    // sender's clock runs slightly fast.
    always_comb begin
        state_d     = state_q;
        cnt_d       = bit_end ? '0 : cnt_q + CNTW'(1);
        samp_d      = samp_q;
        bit_d       = bit_q;
        stop_d      = stop_q;
        shift_d     = shift_q;
        par_bad_d   = par_bad_q;
        frame_bad_d = frame_bad_q;
        armed_d     = armed_q;
        push        = 1'b0;

        if (cnt_q == SAMP_A) samp_d[0] = rx_s;
        if (cnt_q == SAMP_B) samp_d[1] = rx_s;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // armed blocks a held-low line (break) from retriggering.
                if (rx_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d     = ST_START;
                    shift_d     = '0;
                    par_bad_d   = 1'b0;
                    frame_bad_d = 1'b0;
                end
            end
            ST_START: begin
                if (decide && maj) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (bit_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (decide) shift_d[bit_q] = maj;
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
                        stop_d  = 1'b0;
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + BIW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (decide) par_bad_d = maj ^ (^shift_q) ^ PAR_ODD;
                if (bit_end) begin
                    stop_d  = 1'b0;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (decide) begin
                    frame_bad_d = frame_bad_now;
                    if (stop_q == STOP_LAST) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        if (frame_bad_now) armed_d = 1'b0;
                    end
                end else if (bit_end) begin
                    stop_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A push into a full FIFO is accepted only when a pop frees the slot in
    // the same cycle; otherwise the word is dropped and overrun latches.
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign pop   = read_ack_i & ~empty;
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_comb begin
        count_d   = count_q + CW'(wr_en) - CW'(pop);
        overrun_d = overrun_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_q] <= push_entry;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop) rd_q <= rd_q + AW'(1);
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // When empty, show the slot just popped so the outputs hold the last
    // word; after reset that slot is zero.
    assign head_idx = empty ? rd_q - AW'(1) : rd_q;

    assign {data_o, parity_err_o, frame_err_o} = mem_q[head_idx];
    assign data_valid_o = ~empty;
    assign overrun_o    = overrun_q;
    assign fifo_count_o = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Scoreboard bench for uart_rx_fifo at 16 clocks per bit. One instance
//   runs 8N1, a second runs 8E1 for the parity cases. Expected words are
//   queued as frames are sent and compared as the FIFO is drained.
module tb_uart_rx_fifo;

    localparam int CPB = 16;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rxLine;
    logic       useP;
    logic       rxMain, rxPar;
    logic       readAck, readAckP;
    logic       clrOverrun, clrOverrunP;

    logic [7:0] dataMain, dataP;
    logic       peMain, feMain, dataValid, overrunMain;
    logic       peP, feP, validP, overrunP;
    logic [2:0] fifoCount, fifoCountP;

    exp_t       expQ[$];
    int         checks;
    int         errors;

    assign rxMain = useP ? 1'b1 : rxLine;
    assign rxPar  = useP ? rxLine : 1'b1;

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .rx_i(rxMain),
        .data_o(dataMain), .parity_err_o(peMain), .frame_err_o(feMain),
        .data_valid_o(dataValid), .read_ack_i(readAck),
        .overrun_o(overrunMain), .clr_overrun_i(clrOverrun),
        .fifo_count_o(fifoCount)
    );

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dutPar (
        .clk(clk), .rst(rst), .rx_i(rxPar),
        .data_o(dataP), .parity_err_o(peP), .frame_err_o(feP),
        .data_valid_o(validP), .read_ack_i(readAckP),
        .overrun_o(overrunP), .clr_overrun_i(clrOverrunP),
        .fifo_count_o(fifoCountP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pushExpected(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d;
        e.pe   = pe;
        e.fe   = fe;
        expQ.push_back(e);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends one frame bit by bit. glitchBit selects a frame bit (0 = start)
    // that gets a one-cycle inverted pulse on the middle sample. On the
    // final stop bit the push happens on its 13th edge, which is where the
    // latency check and the ack-on-push hook are placed.
    task automatic applyStimulus(input logic [7:0] dat, input bit hasPar, input bit parBit,
                                 input bit stopVal, input int glitchBit,
                                 input bit checkLat, input bit ackOnPush);
        logic frameBits [11];
        int   n;
        frameBits[0] = 1'b0;
        for (int i = 0; i < 8; i++) frameBits[i+1] = dat[i];
        n = 9;
        if (hasPar) begin
            frameBits[n] = parBit;
            n = n + 1;
        end
        frameBits[n] = stopVal;
        n = n + 1;
        for (int i = 0; i < n; i++) begin
            rxLine = frameBits[i];
            for (int k = 1; k <= CPB; k++) begin
                @(posedge clk);
                #1;
                if (i == glitchBit && k == 9)  rxLine = ~frameBits[i];
                if (i == glitchBit && k == 10) rxLine = frameBits[i];
                if (i == n - 1 && k == 12) begin
                    if (checkLat) checkOutput("validBeforePush", dataValid, 0);
                    if (ackOnPush) readAck = 1'b1;
                end
                if (i == n - 1 && k == 13) begin
                    if (checkLat) checkOutput("validAfterPush", dataValid, 1);
                    if (ackOnPush) readAck = 1'b0;
                end
            end
        end
    endtask

    // Waits (bounded) for a word, compares it to the scoreboard head, pops.
    task automatic popAndCheck(input bit onPar);
        exp_t e;
        int   waitCnt;
        waitCnt = 0;
        while (!(onPar ? validP : dataValid) && waitCnt < 400) begin
            @(posedge clk);
            #1;
            waitCnt++;
        end
        if (!(onPar ? validP : dataValid)) begin
            checkOutput("popTimeout", 0, 1);
            return;
        end
        if (expQ.size() == 0) begin
            checkOutput("unexpectedWord", 1, 0);
            return;
        end
        e = expQ.pop_front();
        checkOutput("popData", onPar ? dataP : dataMain, e.data);
        checkOutput("popParityErr", onPar ? peP : peMain, e.pe);
        checkOutput("popFrameErr", onPar ? feP : feMain, e.fe);
        if (onPar) readAckP = 1'b1;
        else       readAck  = 1'b1;
        @(posedge clk);
        #1;
        readAck  = 1'b0;
        readAckP = 1'b0;
    endtask

    initial begin
        exp_t e;
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        rxLine      = 1'b1;
        useP        = 1'b0;
        readAck     = 1'b0;
        readAckP    = 1'b0;
        clrOverrun  = 1'b0;
        clrOverrunP = 1'b0;
        waitCycles(3);

        checkOutput("rstData", dataMain, 0);
        checkOutput("rstValid", dataValid, 0);
        checkOutput("rstParityErr", peMain, 0);
        checkOutput("rstFrameErr", feMain, 0);
        checkOutput("rstOverrun", overrunMain, 0);
        checkOutput("rstCount", fifoCount, 0);

        rst = 1'b0;
        waitCycles(10);

        // Basic 8N1 frame with exact push latency, then drain.
        pushExpected(8'hA5, 1'b0, 1'b0);
        applyStimulus(8'hA5, 0, 0, 1, -1, 1, 0);
        popAndCheck(0);
        checkOutput("validAfterPop", dataValid, 0);
        checkOutput("countAfterPop", fifoCount, 0);
        checkOutput("dataHeldAfterPop", dataMain, 8'hA5);

        // Short low pulse on the line is rejected as a false start bit.
        rxLine = 1'b0;
        waitCycles(6);
        rxLine = 1'b1;
        waitCycles(3 * CPB);
        checkOutput("startGlitchCount", fifoCount, 0);
        checkOutput("startGlitchValid", dataValid, 0);

        // One-cycle glitch inside data bit 1 is outvoted.
        pushExpected(8'h5A, 1'b0, 1'b0);
        applyStimulus(8'h5A, 0, 0, 1, 2, 0, 0);
        popAndCheck(0);

        // Bad stop bit followed by a long break: exactly one word.
        pushExpected(8'h55, 1'b0, 1'b1);
        applyStimulus(8'h55, 0, 0, 0, -1, 0, 0);
        rxLine = 1'b0;
        waitCycles(40 * CPB);
        checkOutput("breakCount", fifoCount, 1);
        rxLine = 1'b1;
        waitCycles(2 * CPB);
        pushExpected(8'h12, 1'b0, 1'b0);
        applyStimulus(8'h12, 0, 0, 1, -1, 0, 0);
        checkOutput("afterBreakCount", fifoCount, 2);
        popAndCheck(0);
        popAndCheck(0);

        // Five frames into a four-entry FIFO with no reads.
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) pushExpected(8'(i), 1'b0, 1'b0);
            applyStimulus(8'(i), 0, 0, 1, -1, 0, 0);
        end
        checkOutput("fullCount", fifoCount, 4);
        checkOutput("overrunSet", overrunMain, 1);
        for (int i = 0; i < 4; i++) popAndCheck(0);
        checkOutput("overrunSticky", overrunMain, 1);
        clrOverrun = 1'b1;
        waitCycles(1);
        clrOverrun = 1'b0;
        checkOutput("overrunCleared", overrunMain, 0);

        // Full FIFO with a pop on the push cycle: no overrun, count holds.
        for (int i = 0; i < 4; i++) begin
            pushExpected(8'h21 + 8'(i), 1'b0, 1'b0);
            applyStimulus(8'h21 + 8'(i), 0, 0, 1, -1, 0, 0);
        end
        checkOutput("fullAgainCount", fifoCount, 4);
        e = expQ.pop_front();
        checkOutput("headBeforeAckPush", dataMain, e.data);
        pushExpected(8'h25, 1'b0, 1'b0);
        applyStimulus(8'h25, 0, 0, 1, -1, 0, 1);
        checkOutput("ackPushOverrun", overrunMain, 0);
        checkOutput("ackPushCount", fifoCount, 4);
        for (int i = 0; i < 4; i++) popAndCheck(0);

        // Reset in the middle of a frame with words stored.
        applyStimulus(8'h66, 0, 0, 1, -1, 0, 0);
        applyStimulus(8'h77, 0, 0, 1, -1, 0, 0);
        checkOutput("preResetCount", fifoCount, 2);
        rxLine = 1'b0;
        waitCycles(CPB);
        rxLine = 1'b1;
        waitCycles(CPB);
        rxLine = 1'b0;
        waitCycles(CPB / 2);
        rst = 1'b1;
        rxLine = 1'b1;
        #1;
        checkOutput("midRstData", dataMain, 0);
        checkOutput("midRstValid", dataValid, 0);
        checkOutput("midRstCount", fifoCount, 0);
        checkOutput("midRstOverrun", overrunMain, 0);
        checkOutput("midRstFrameErr", feMain, 0);
        waitCycles(3);
        rst = 1'b0;
        waitCycles(4 * CPB);
        checkOutput("noPartialPush", fifoCount, 0);
        pushExpected(8'h3C, 1'b0, 1'b0);
        applyStimulus(8'h3C, 0, 0, 1, -1, 0, 0);
        popAndCheck(0);

        // Even parity: 0x37 has five ones, so the correct parity bit is 1.
        useP = 1'b1;
        waitCycles(2 * CPB);
        pushExpected(8'h37, 1'b0, 1'b0);
        applyStimulus(8'h37, 1, 1, 1, -1, 0, 0);
        pushExpected(8'h37, 1'b1, 1'b0);
        applyStimulus(8'h37, 1, 0, 1, -1, 0, 0);
        checkOutput("parCount", fifoCountP, 2);
        popAndCheck(1);
        popAndCheck(1);
        checkOutput("parEmpty", validP, 0);
        checkOutput("mainIdleDuringPar", fifoCount, 0);
        useP = 1'b0;

        checkOutput("scoreboardDrained", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
